// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B controller: one full-subtractor cell reused LSB-first over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             Ovf
`endif
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] sa, sb, res;
   logic             br;
   logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb, b_msb;
`endif

   logic             hs1_d, hs1_b, bit_d, hs2_b, br_next;
   logic [WIDTH-1:0] res_next;

   // Two cascaded half-subtractors form the shared bit cell.
   always_comb begin
      hs1_d    = sa[0] ^ sb[0];
      hs1_b    = ~sa[0] & sb[0];
      bit_d    = hs1_d ^ br;
      hs2_b    = ~hs1_d & br;
      br_next  = hs1_b | hs2_b;
      res_next = {bit_d, res[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         br     <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         Diff   <= '0;
         Borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         Ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa    <= A;
                  sb    <= B;
                  res   <= '0;
                  br    <= 1'b0;
                  cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb <= A[WIDTH-1];
                  b_msb <= B[WIDTH-1];
`endif
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_next;
               res <= res_next;
               // Outputs load from the final step's next values so they are valid during DONE.
               if (cnt == LAST) begin
                  Diff   <= res_next;
                  Borrow <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                  Ovf    <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
                  done   <= 1'b1;
                  state  <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8); an independent cycle model
// predicts accepts, done timing, busy and the held result registers.
module tb_serial_subtractor_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n, start;
   logic [W-1:0] a, b;
   logic         busy, done, borrow;
   logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (a),
      .B      (b),
      .busy   (busy),
      .done   (done),
      .Diff   (diff),
      .Borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .Ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
      int unsigned  acc;
   } exp_t;

   exp_t         exp_q[$];
   int unsigned  n_checks = 0;
   int unsigned  n_errors = 0;
   int unsigned  cyc = 0;
   int unsigned  m_cnt = 0;
   bit           chk_en = 1'b0;
   logic [W-1:0] exp_diff = '0;
   logic         exp_borrow = 1'b0;
   logic         exp_ovf = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
      end
   endtask

   // Reference model: decides accepts on its own and pushes the expected result.
   always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
         m_cnt = 0;
         exp_q.delete();
         exp_diff   = '0;
         exp_borrow = 1'b0;
         exp_ovf    = 1'b0;
         chk_en     = 1'b1;
      end else if (m_cnt == 0) begin
         if (start) begin
            exp_t e;
            e.d   = a - b;
            e.bo  = (a < b);
            e.ov  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
            e.acc = cyc;
            exp_q.push_back(e);
            m_cnt = W + 1;
         end
      end else begin
         m_cnt--;
      end
   end

   // Monitor on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         bit exp_done;
         exp_done = (exp_q.size() > 0) && (cyc == exp_q[0].acc + W);
         check("done", {31'b0, done}, {31'b0, exp_done});
         if (exp_done) begin
            exp_t e;
            e = exp_q.pop_front();
            exp_diff   = e.d;
            exp_borrow = e.bo;
            exp_ovf    = e.ov;
         end
         check("busy", {31'b0, busy}, {31'b0, (m_cnt != 0)});
         check("diff", {24'b0, diff}, {24'b0, exp_diff});
         check("borrow", {31'b0, borrow}, {31'b0, exp_borrow});
`ifdef SERIAL_SUB_OVF_EN
         check("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
`endif
      end
   end

   task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb);
      a = va;
      b = vb;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (W + 2) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_op(8'h35, 8'h12);
      run_op(8'h12, 8'h35);
      run_op(8'h00, 8'h01);
      run_op(8'hFF, 8'hFF);

      // Second start while busy must be ignored.
      a = 8'h50; b = 8'h10; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 a = 8'h01; b = 8'h01; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (W + 2) @(posedge clk);
      #1;

      // Reset in the middle of RUN discards the operation.
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (W + 2) @(posedge clk);
      #1;
      run_op(8'h09, 8'h03);

      run_op(8'h80, 8'h01);
      run_op(8'h7F, 8'hFF);
      run_op(8'h05, 8'h03);

      for (int i = 0; i < 6; i++) begin
         run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      end

      // Start held high: back-to-back operations.
      a = 8'h10; b = 8'h01; start = 1'b1;
      repeat (30) @(posedge clk);
      #1 start = 1'b0;
      repeat (W + 4) @(posedge clk);
      #1;

      check("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial subtraction controller. It loads two WIDTH-bit operands on a start handshake and computes A − B one bit per cycle, LSB first. Each step uses a single registered borrow around a full-subtractor bit cell built from two half-subtractor stages. The block sequences that shared 1-bit datapath over WIDTH cycles and presents the registered difference and final borrow with a done pulse. It sits between operand producers and any consumer needing area-minimal subtraction.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on an accepted start.
- B  input  WIDTH  subtrahend; captured on an accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result is valid.
- Diff  output  WIDTH  A − B modulo 2^WIDTH; held until the next accepted start.
- Borrow  output  1  final borrow out; 1 when A < B (unsigned).
- Ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States and transitions:
  - IDLE → RUN on start=1, which is an accepted start.
  - RUN → DONE when the bit counter reaches WIDTH−1 and that bit is processed.
  - DONE → IDLE unconditionally after one cycle.
- Accepted start (IDLE only):
  - Load internal shift registers sa←A, sb←B.
  - Clear the borrow register, the bit counter and the result shift register.
  - Diff and Borrow outputs do not change on an accepted start; they keep the previous result until DONE.
- RUN, each cycle, processing bit i = counter:
  - d = sa[0] ^ sb[0] ^ br.
  - br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br).
  - Shift sa and sb right by one.
  - Shift d into the MSB of the result register, so after WIDTH shifts bit 0 lands in the LSB.
  - Increment the counter.
- DONE:
  - Diff ← result register; Borrow ← br.
  - done=1 for exactly this cycle.
- start while busy (RUN or DONE) is ignored; there is no queueing.
- The counter is $clog2(WIDTH) bits wide. It never wraps: it stops at WIDTH−1 and is cleared on the next accepted start.
- Reset, any state, including mid-RUN:
  - Next edge: state=IDLE; busy=0, done=0, Diff=0, Borrow=0, Ovf=0.
  - All internal registers are zeroed.
  - The in-flight operation is discarded and produces no done.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycles 1..WIDTH: RUN; busy=1.
- Cycle WIDTH+1: DONE; done=1, busy=1; Diff, Borrow and Ovf are updated at this edge.
- Cycle WIDTH+2: IDLE; busy=0. A new start is accepted at this edge at the earliest.
- Latency from start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- start held high continuously gives back-to-back operations spaced WIDTH+2 cycles apart. Each operation captures A and B at its own accept edge.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - The Ovf port exists.
  - The MSBs of A and B are captured at accept; no extra shifting is needed.
  - At DONE, Ovf ← (A[W−1] ≠ B[W−1]) & (Diff_next[W−1] ≠ A[W−1]).
  - Ovf holds with Diff and resets to 0.
- SERIAL_SUB_OVF_EN not defined:
  - The Ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, A=0x35, B=0x12, start pulse → done exactly 9 cycles later; Diff=0x23, Borrow=0; busy low on the following cycle.
- A=0x12, B=0x35 → Diff=0xDD, Borrow=1. Then A=0x00, B=0x01 → Diff=0xFF, Borrow=1. Then A=0xFF, B=0xFF → Diff=0x00, Borrow=0.
- Start A=0x50, B=0x10; 3 cycles later pulse start with A=0x01, B=0x01 → the second start is ignored; a single done with Diff=0x40, Borrow=0.
- Start A=0xAA, B=0x55; drive rst_n=0 for one cycle during RUN → next edge: busy=0, Diff=0, Borrow=0; no done pulse. A later start with A=0x09, B=0x03 → Diff=0x06.
- With SERIAL_SUB_OVF_EN: A=0x80, B=0x01 → Diff=0x7F, Borrow=0, Ovf=1. A=0x7F, B=0xFF → Diff=0x80, Borrow=1, Ovf=1. A=0x05, B=0x03 → Ovf=0.
- start held high for 30 cycles with fixed A=0x10, B=0x01 → done pulses at cycles 9, 19 and 29 relative to the first accept; Diff=0x0F each time.
